// File: rtl/ram_loader.sv
// Streams bytes into an asynchronous SRAM with a SETUP/WRITE/HOLD strobe sequence,
// then optionally reads every location back and compares it against a shadow copy.
module ram_loader #(
   parameter logic [3:0] LAST_ADDR = 4'hF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       verify_en,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [3:0] mem_address,
   output logic [7:0] mem_data,
   output logic       mem_we_n,
   output logic       mem_oe_n,
   input  logic [7:0] mem_bus,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [3:0] error_addr
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ACCEPT,
      S_SETUP,
      S_WRITE,
      S_HOLD,
      S_RD_ADDR,
      S_RD_CMP,
      S_DONE,
      S_ERROR
   } state_t;

   state_t     state;
   logic       verify_q;
   logic [7:0] shadow [0:15];

   // Shadow copy of every accepted byte; deliberately not reset, a new pass rewrites it.
   always_ff @(posedge clk) begin
      if (!reset && state == S_ACCEPT && in_valid)
         shadow[mem_address] <= in_data;
   end

   // All outputs are registered and updated on the edge that enters the state they belong to,
   // so mem_address doubles as the pass address counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         verify_q    <= 1'b0;
         in_ready    <= 1'b0;
         mem_address <= 4'h0;
         mem_data    <= 8'h00;
         mem_we_n    <= 1'b1;
         mem_oe_n    <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         error_addr  <= 4'h0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state       <= S_ACCEPT;
                  verify_q    <= verify_en;
                  mem_address <= 4'h0;
                  in_ready    <= 1'b1;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  error       <= 1'b0;
                  error_addr  <= 4'h0;
               end
            end

            S_ACCEPT: begin
               if (in_valid) begin
                  mem_data <= in_data;
                  in_ready <= 1'b0;
                  state    <= S_SETUP;
               end
            end

            S_SETUP: begin
               mem_we_n <= 1'b0;
               state    <= S_WRITE;
            end

            S_WRITE: begin
               mem_we_n <= 1'b1;
               state    <= S_HOLD;
            end

            // Address only moves on leaving HOLD, keeping it stable around the strobe.
            S_HOLD: begin
               if (mem_address < LAST_ADDR) begin
                  mem_address <= mem_address + 4'd1;
                  in_ready    <= 1'b1;
                  state       <= S_ACCEPT;
               end else if (verify_q) begin
                  mem_address <= 4'h0;
                  mem_oe_n    <= 1'b0;
                  state       <= S_RD_ADDR;
               end else begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end

            S_RD_ADDR: begin
               state <= S_RD_CMP;
            end

            S_RD_CMP: begin
               if (mem_bus != shadow[mem_address]) begin
                  error      <= 1'b1;
                  error_addr <= mem_address;
                  busy       <= 1'b0;
                  mem_oe_n   <= 1'b1;
                  state      <= S_ERROR;
               end else if (mem_address == LAST_ADDR) begin
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  mem_oe_n <= 1'b1;
                  state    <= S_DONE;
               end else begin
                  mem_address <= mem_address + 4'd1;
                  state       <= S_RD_ADDR;
               end
            end

            default: begin
               state    <= S_IDLE;
               in_ready <= 1'b0;
               mem_we_n <= 1'b1;
               mem_oe_n <= 1'b1;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: behavioural SRAM with fault injection plus a bus monitor.
module tb_ram_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       verify_en;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] mem_address;
   logic [7:0] mem_data;
   logic       mem_we_n;
   logic       mem_oe_n;
   logic [7:0] mem_bus;
   logic       busy;
   logic       done;
   logic       error;
   logic [3:0] error_addr;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] data_base = 8'h10;
   logic       fault_en = 1'b0;
   logic [3:0] fault_addr = 4'h5;
   logic [7:0] ram [0:15];

   // monitor state
   int         we_cnt, oe_cnt, stab_err, both_low, max_rd_addr;
   logic [3:0] we_addr_log [0:15];
   logic [7:0] we_data_log [0:15];
   logic [3:0] prev_addr;
   logic [7:0] prev_data;
   logic       prev_we_n = 1'b1;

   ram_loader #(.LAST_ADDR(4'hF)) dut (
      .clk(clk), .reset(reset), .start(start), .verify_en(verify_en),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mem_address(mem_address), .mem_data(mem_data), .mem_we_n(mem_we_n),
      .mem_oe_n(mem_oe_n), .mem_bus(mem_bus), .busy(busy), .done(done),
      .error(error), .error_addr(error_addr)
   );

   always #5 clk = ~clk;

   always_comb in_data = data_base + {4'h0, mem_address};

   always @(posedge clk)
      if (mem_we_n === 1'b0) ram[mem_address] <= mem_data;

   assign mem_bus = (mem_oe_n === 1'b0)
                  ? ((fault_en && mem_address == fault_addr) ? 8'hFF : ram[mem_address])
                  : 8'hzz;

   always @(negedge clk) begin
      if (mem_we_n === 1'b0) begin
         if (we_cnt < 16) begin
            we_addr_log[we_cnt] = mem_address;
            we_data_log[we_cnt] = mem_data;
         end
         we_cnt++;
         if (mem_address !== prev_addr || mem_data !== prev_data) stab_err++;
         if (prev_we_n === 1'b0) stab_err++;
      end
      if (prev_we_n === 1'b0 && (mem_address !== prev_addr || mem_data !== prev_data)) stab_err++;
      if (mem_oe_n === 1'b0) begin
         oe_cnt++;
         if (int'(mem_address) > max_rd_addr) max_rd_addr = int'(mem_address);
      end
      if (mem_we_n === 1'b0 && mem_oe_n === 1'b0) both_low++;
      prev_addr = mem_address;
      prev_data = mem_data;
      prev_we_n = mem_we_n;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clr_mon;
      we_cnt = 0; oe_cnt = 0; stab_err = 0; both_low = 0; max_rd_addr = -1;
   endtask

   task automatic begin_pass(input logic ve);
      clr_mon();
      start = 1'b1;
      verify_en = ve;
      tick();
      start = 1'b0;
      verify_en = 1'b0;
   endtask

   task automatic wait_end(input int max_cyc, output logic fin);
      fin = 1'b0;
      for (int i = 0; i < max_cyc && !fin; i++) begin
         if (done === 1'b1 || error === 1'b1) fin = 1'b1;
         else tick();
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b1; verify_en = 1'b1; in_valid = 1'b1;
      repeat (3) tick();
      vectors += 9;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      if (mem_address !== 4'h0) begin miscompares++; $display("FAIL reset_addr got %h want 0", mem_address); end
      if (mem_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", mem_data); end
      if (mem_we_n !== 1'b1) begin miscompares++; $display("FAIL reset_we_n got %b want 1", mem_we_n); end
      if (mem_oe_n !== 1'b1) begin miscompares++; $display("FAIL reset_oe_n got %b want 1", mem_oe_n); end
      if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
      if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
      if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error got %b want 0", error); end
      if (error_addr !== 4'h0) begin miscompares++; $display("FAIL reset_error_addr got %h want 0", error_addr); end
      start = 1'b0; verify_en = 1'b0; reset = 1'b0;
      tick();
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_after_reset_busy got %b want 0", busy); end
   endtask

   task automatic test_write_pass;
      logic fin;
      data_base = 8'h10; in_valid = 1'b1;
      begin_pass(1'b0);
      vectors += 2;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL wr_first_ready got %b want 1", in_ready); end
      if (busy !== 1'b1) begin miscompares++; $display("FAIL wr_busy got %b want 1", busy); end
      wait_end(200, fin);
      vectors += 7;
      if (fin !== 1'b1) begin miscompares++; $display("FAIL wr_timeout got %b want 1", fin); end
      if (done !== 1'b1) begin miscompares++; $display("FAIL wr_done got %b want 1", done); end
      if (error !== 1'b0) begin miscompares++; $display("FAIL wr_error got %b want 0", error); end
      if (busy !== 1'b0) begin miscompares++; $display("FAIL wr_busy_end got %b want 0", busy); end
      if (we_cnt !== 16) begin miscompares++; $display("FAIL wr_strobes got %0d want 16", we_cnt); end
      if (stab_err !== 0) begin miscompares++; $display("FAIL wr_stability got %0d want 0", stab_err); end
      if (oe_cnt !== 0) begin miscompares++; $display("FAIL wr_no_reads got %0d want 0", oe_cnt); end
      for (int i = 0; i < 16; i++) begin
         vectors += 3;
         if (we_addr_log[i] !== 4'(i)) begin miscompares++; $display("FAIL wr_addr[%0d] got %h want %h", i, we_addr_log[i], 4'(i)); end
         if (we_data_log[i] !== 8'h10 + 8'(i)) begin miscompares++; $display("FAIL wr_data[%0d] got %h want %h", i, we_data_log[i], 8'h10 + 8'(i)); end
         if (ram[i] !== 8'h10 + 8'(i)) begin miscompares++; $display("FAIL wr_ram[%0d] got %h want %h", i, ram[i], 8'h10 + 8'(i)); end
      end
      tick(); tick();
      vectors++;
      if (done !== 1'b1) begin miscompares++; $display("FAIL wr_done_held got %b want 1", done); end
   endtask

   task automatic test_verify_ok;
      logic fin;
      data_base = 8'h40; in_valid = 1'b1; fault_en = 1'b0;
      begin_pass(1'b1);
      wait_end(300, fin);
      vectors += 7;
      if (fin !== 1'b1) begin miscompares++; $display("FAIL vok_timeout got %b want 1", fin); end
      if (done !== 1'b1) begin miscompares++; $display("FAIL vok_done got %b want 1", done); end
      if (error !== 1'b0) begin miscompares++; $display("FAIL vok_error got %b want 0", error); end
      if (oe_cnt !== 32) begin miscompares++; $display("FAIL vok_read_cycles got %0d want 32", oe_cnt); end
      if (max_rd_addr !== 15) begin miscompares++; $display("FAIL vok_max_rd got %0d want 15", max_rd_addr); end
      if (both_low !== 0) begin miscompares++; $display("FAIL vok_we_oe_both_low got %0d want 0", both_low); end
      if (mem_oe_n !== 1'b1) begin miscompares++; $display("FAIL vok_oe_end got %b want 1", mem_oe_n); end
   endtask

   task automatic test_verify_err;
      logic fin;
      data_base = 8'h20; in_valid = 1'b1; fault_en = 1'b1; fault_addr = 4'h5;
      begin_pass(1'b1);
      vectors++;
      if (done !== 1'b0) begin miscompares++; $display("FAIL verr_done_cleared got %b want 0", done); end
      wait_end(300, fin);
      repeat (3) tick();
      vectors += 7;
      if (fin !== 1'b1) begin miscompares++; $display("FAIL verr_timeout got %b want 1", fin); end
      if (error !== 1'b1) begin miscompares++; $display("FAIL verr_error got %b want 1", error); end
      if (error_addr !== 4'h5) begin miscompares++; $display("FAIL verr_error_addr got %h want 5", error_addr); end
      if (done !== 1'b0) begin miscompares++; $display("FAIL verr_done got %b want 0", done); end
      if (busy !== 1'b0) begin miscompares++; $display("FAIL verr_busy got %b want 0", busy); end
      if (max_rd_addr !== 5) begin miscompares++; $display("FAIL verr_max_rd got %0d want 5", max_rd_addr); end
      if (oe_cnt !== 12) begin miscompares++; $display("FAIL verr_read_cycles got %0d want 12", oe_cnt); end
      fault_en = 1'b0;
   endtask

   task automatic test_stall;
      int   stalls = 0;
      logic fin = 1'b0;
      data_base = 8'h60; in_valid = 1'b1;
      begin_pass(1'b0);
      for (int i = 0; i < 300 && !fin; i++) begin
         if (done === 1'b1) fin = 1'b1;
         else begin
            if (in_ready === 1'b1 && mem_address == 4'h3 && stalls < 4) begin
               vectors += 3;
               if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_ready got %b want 1", in_ready); end
               if (mem_we_n !== 1'b1) begin miscompares++; $display("FAIL stall_we_n got %b want 1", mem_we_n); end
               if (mem_address !== 4'h3) begin miscompares++; $display("FAIL stall_addr got %h want 3", mem_address); end
               in_valid = 1'b0;
               stalls++;
            end else in_valid = 1'b1;
            tick();
         end
      end
      in_valid = 1'b1;
      vectors += 5;
      if (fin !== 1'b1) begin miscompares++; $display("FAIL stall_timeout got %b want 1", fin); end
      if (stalls !== 4) begin miscompares++; $display("FAIL stall_count got %0d want 4", stalls); end
      if (we_cnt !== 16) begin miscompares++; $display("FAIL stall_strobes got %0d want 16", we_cnt); end
      if (ram[3] !== 8'h63) begin miscompares++; $display("FAIL stall_ram3 got %h want 63", ram[3]); end
      if (stab_err !== 0) begin miscompares++; $display("FAIL stall_stability got %0d want 0", stab_err); end
   endtask

   task automatic test_start_ignored;
      logic       fin;
      logic [3:0] a0;
      data_base = 8'h50; in_valid = 1'b1;
      begin_pass(1'b0);
      repeat (10) tick();
      a0 = mem_address;
      start = 1'b1;
      tick();
      start = 1'b0;
      vectors += 2;
      if (busy !== 1'b1) begin miscompares++; $display("FAIL sbusy_busy got %b want 1", busy); end
      if (mem_address < a0) begin miscompares++; $display("FAIL sbusy_addr got %h want >= %h", mem_address, a0); end
      wait_end(200, fin);
      vectors += 3;
      if (fin !== 1'b1) begin miscompares++; $display("FAIL sbusy_timeout got %b want 1", fin); end
      if (we_cnt !== 16) begin miscompares++; $display("FAIL sbusy_strobes got %0d want 16", we_cnt); end
      if (ram[15] !== 8'h5F) begin miscompares++; $display("FAIL sbusy_ram15 got %h want 5f", ram[15]); end
   endtask

   task automatic test_reset_in_write;
      logic found = 1'b0;
      logic fin;
      data_base = 8'h70; in_valid = 1'b1;
      begin_pass(1'b0);
      for (int i = 0; i < 200 && !found; i++) begin
         if (mem_we_n === 1'b0 && mem_address == 4'h7) found = 1'b1;
         else tick();
      end
      reset = 1'b1;
      tick();
      vectors += 5;
      if (found !== 1'b1) begin miscompares++; $display("FAIL rstw_reach_write7 got %b want 1", found); end
      if (mem_we_n !== 1'b1) begin miscompares++; $display("FAIL rstw_we_n got %b want 1", mem_we_n); end
      if (busy !== 1'b0) begin miscompares++; $display("FAIL rstw_busy got %b want 0", busy); end
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rstw_in_ready got %b want 0", in_ready); end
      if (mem_address !== 4'h0) begin miscompares++; $display("FAIL rstw_addr got %h want 0", mem_address); end
      reset = 1'b0;
      tick();
      data_base = 8'h80;
      begin_pass(1'b0);
      vectors += 2;
      if (mem_address !== 4'h0) begin miscompares++; $display("FAIL rstw_restart_addr got %h want 0", mem_address); end
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstw_restart_ready got %b want 1", in_ready); end
      wait_end(200, fin);
      vectors += 3;
      if (fin !== 1'b1) begin miscompares++; $display("FAIL rstw_timeout got %b want 1", fin); end
      if (ram[0] !== 8'h80) begin miscompares++; $display("FAIL rstw_ram0 got %h want 80", ram[0]); end
      if (ram[7] !== 8'h87) begin miscompares++; $display("FAIL rstw_ram7 got %h want 87", ram[7]); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; verify_en = 1'b0; in_valid = 1'b0;
      clr_mon();
      test_reset();
      test_write_pass();
      test_verify_ok();
      test_verify_err();
      test_stall();
      test_start_ignored();
      test_reset_in_write();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
